// File: rtl/pad_event_arbiter_pkg.sv
// Shared constants for the pad button event arbiter.
// Imported by the arbiter top and its round-robin search.
package pad_event_arbiter_pkg;

    localparam int N_BTN_DEF = 8;
    localparam int ID_W      = $clog2(N_BTN_DEF);
    localparam int DROP_W    = 8;

    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

endpackage

// File: rtl/pad_rr_arbiter.sv
// Combinational round-robin search over pending requests.
// The search starts one past the previous winner and wraps to index 0.
module pad_rr_arbiter
    import pad_event_arbiter_pkg::*;
#(
    parameter int N_BTN = N_BTN_DEF,
    localparam int IW   = $clog2(N_BTN)
) (
    input  logic [N_BTN-1:0] req,
    input  logic [IW-1:0]    last_grant,
    input  logic             en,
    output logic             gnt_valid,
    output logic [IW-1:0]    gnt_id
);

    int idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        for (int k = 1; k <= N_BTN; k++) begin
            idx = (int'(last_grant) + k) % N_BTN;
            if (en && !gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_id    = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/pad_event_arbiter.sv
// Turns button press edges into a one-deep event stream with
// round-robin fairness, pending flags and a saturating drop count.
module pad_event_arbiter
    import pad_event_arbiter_pkg::*;
#(
    parameter int N_BTN = N_BTN_DEF,
    localparam int IW   = $clog2(N_BTN)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N_BTN-1:0]  btn,
    input  logic              evt_ready,
    output logic              evt_valid,
    output logic [IW-1:0]     evt_id,
    output logic [N_BTN-1:0]  pending,
    output logic              drop,
    output logic [DROP_W-1:0] drop_cnt
);

    logic [N_BTN-1:0] btn_q;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] gnt_mask;
    logic [N_BTN-1:0] pending_nxt;
    logic [IW-1:0]    last_grant;
    logic             slot_free;
    logic             gnt_valid;
    logic [IW-1:0]    gnt_id;

    assign rise      = btn & ~btn_q;
    assign slot_free = ~evt_valid | evt_ready;

    pad_rr_arbiter #(
        .N_BTN (N_BTN)
    ) u_rr (
        .req        (pending),
        .last_grant (last_grant),
        .en         (slot_free),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    always_comb begin
        gnt_mask = '0;
        if (gnt_valid)
            gnt_mask[gnt_id] = 1'b1;
    end

    // A rise on the granted button re-arms it instead of being lost
    assign pending_nxt = (pending & ~gnt_mask) | rise;
    assign drop        = ~RST & (|(rise & pending & ~gnt_mask));

    always_ff @(posedge CLK) begin
        if (RST) begin
            btn_q      <= btn;
            pending    <= '0;
            evt_valid  <= 1'b0;
            evt_id     <= '0;
            drop_cnt   <= '0;
            last_grant <= IW'(N_BTN - 1);
        end else begin
            btn_q   <= btn;
            pending <= pending_nxt;
            if (gnt_valid) begin
                evt_valid  <= 1'b1;
                evt_id     <= gnt_id;
                last_grant <= gnt_id;
            end else if (slot_free) begin
                evt_valid <= 1'b0;
            end
            if (drop && drop_cnt != DROP_MAX)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: doc/pad_event_arbiter.md
PAD_EVENT_ARBITER -- requirements
Module: pad_event_arbiter

Interface
REQ-001 The block SHALL have one parameter: N_BTN, default 8, number of pad button inputs (2..16).
REQ-002 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 btn  input  N_BTN  raw button levels, already synchronous to CLK; 1 = pressed.
REQ-005 evt_ready  input  1  consumer accepts the presented event this cycle.
REQ-006 evt_valid  output  1  an event is presented.
REQ-007 evt_id  output  clog2(N_BTN)  index of the button whose press is presented.
REQ-008 pending  output  N_BTN  per-button press-waiting-for-grant flags.
REQ-009 drop  output  1  one-cycle pulse: at least one press was lost this cycle.
REQ-010 drop_cnt  output  8  saturating count of cycles in which drop was asserted.

Function
REQ-011 The block SHALL register btn into btn_q every cycle; rise[i] = btn[i] & ~btn_q[i].
REQ-012 rise[i] SHALL set pending[i] at the end of the same cycle.
REQ-013 A grant to button i SHALL clear pending[i] at the end of the grant cycle, unless rise[i] is also high that cycle; in that case pending[i] SHALL stay 1.
REQ-014 rise[i] while pending[i]=1 and i not granted that cycle SHALL be dropped: pending[i] unchanged, drop=1 for that cycle.
REQ-015 The output slot is free when evt_valid=0 or (evt_valid & evt_ready); a grant SHALL occur only when the slot is free and pending is non-zero.
REQ-016 Grant selection SHALL be round-robin: search starts at (last_grant+1) mod N_BTN and takes the first pending index, wrapping past N_BTN-1 to 0.
REQ-017 On a grant, evt_valid SHALL be 1 and evt_id SHALL be the granted index from the next cycle.
REQ-018 While evt_valid=1 and evt_ready=0, evt_valid and evt_id SHALL hold stable.
REQ-019 evt_valid & evt_ready with no pending press SHALL drop evt_valid to 0 the next cycle.
REQ-020 evt_valid & evt_ready with a pending press SHALL load the next winner back-to-back, sustaining 1 event/cycle.
REQ-021 Latency: a press first sampled in cycle n, with the slot free and no competitors, SHALL give evt_valid=1 in cycle n+2.
REQ-022 Several simultaneous rises SHALL all set pending; they are granted one per free slot in round-robin order.
REQ-023 drop_cnt SHALL increment by 1 in each cycle with drop=1 and saturate at 255.
REQ-024 evt_ready while evt_valid=0 SHALL have no effect.

Reset
REQ-025 During RST: btn_q SHALL load the current btn (a button held through reset generates no event); pending=0; evt_valid=0; evt_id=0; drop=0; drop_cnt=0; last_grant=N_BTN-1, so index 0 has top priority first.
REQ-026 RST asserted mid-handshake SHALL discard the presented event and all pending presses, with no drop pulse.

Structure
REQ-027 A shared package SHALL hold N_BTN default, ID width constant (clog2), and the drop counter width (8).
REQ-028 The round-robin search SHALL be a sub-module pad_rr_arbiter.
  - Inputs: req[N_BTN], last_grant, en.
  - Outputs: gnt_valid, gnt_id.
  - Purely combinational; last_grant register stays in the parent.
REQ-029 Edge detection, pending flags, output slot and drop counter SHALL live in pad_event_arbiter.

Verification
REQ-030 Single press: reset, then btn[3] 0->1 at cycle 5, evt_ready=1 -> evt_valid=1, evt_id=3 at cycle 7 only; pending[3]=1 at cycle 6 only.
REQ-031 Simultaneous: btn=0x0B rises at once, evt_ready=1 -> evt_id 0,1,3 on consecutive cycles; pending clears one bit per cycle.
REQ-032 Backpressure and wrap: grant 6, hold evt_ready=0 for 4 cycles while btn[1] and btn[7] pend -> evt_id=6 held stable, then 7, then 1.
REQ-033 Drop: btn[2] pulses 0->1->0->1 in 4 cycles with evt_ready=0 and slot occupied -> second rise gives drop=1 for one cycle, drop_cnt=1, pending[2] stays 1.
REQ-034 Reset edge cases:
  - btn[5] held through RST -> no event afterwards.
  - RST asserted with evt_valid=1 -> evt_valid=0, pending=0 next cycle.
  - 300 drop cycles -> drop_cnt=255.
